cmp_sched: RTL and testbench

Round-robin scheduler that shares one 2-bit magnitude-compare unit among `NREQ` requesters, each presenting a pair of `WIDTH`-bit unsigned operands. A granted request is compared serially, one 2-bit digit per cycle, MSB first. The block returns a one-hot eq/gt/lt result tagged with the requester index. It sits between the operand producers and any consumer of compare results that can tolerate multi-cycle latency.

---
 rtl/cmp_pkg.sv | 18 +
 rtl/cmp2_unit.sv | 16 +
 rtl/cmp_sched.sv | 188 ++++++++++++++++++
 tb/tb_cmp_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the cmp_sched serial-compare scheduler.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CMP_DIGIT_W = 2;

  // One-hot result encoding {eq, gt, lt}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/cmp2_unit.sv
// Combinational unsigned compare of one 2-bit digit pair, one-hot eq/gt/lt.
module cmp2_unit
  import cmp_pkg::*;
(
  input  logic [CMP_DIGIT_W-1:0] a,
  input  logic [CMP_DIGIT_W-1:0] b,
  output logic                   eq,
  output logic                   gt,
  output logic                   lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/cmp_sched.sv
// Round-robin scheduler sharing one 2-bit compare unit, MSB-first serial scan.
// Define CMP_EARLY_EXIT_EN to leave the scan right after the first unequal digit.
module cmp_sched
  import cmp_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_eq,
  output logic                     rsp_gt,
  output logic                     rsp_lt
);

  localparam int IW   = $clog2(NREQ);
  localparam int NDIG = WIDTH / CMP_DIGIT_W;
  localparam int JW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e              state_r;
  logic [IW-1:0]       ptr_r;
  logic [IW-1:0]       id_r;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic [JW-1:0]       j_r;
  logic                decided_r;
  logic [2:0]          res_r;
  logic                rsp_valid_r;
  logic [2:0]          rsp_res_r;

  logic [NREQ-1:0]        gnt_s;
  logic [IW-1:0]          gnt_idx_s;
  logic [WIDTH-1:0]       a_sel_s;
  logic [WIDTH-1:0]       b_sel_s;
  logic [CMP_DIGIT_W-1:0] a_dig_s;
  logic [CMP_DIGIT_W-1:0] b_dig_s;
  logic                   u_eq_s;
  logic                   u_gt_s;
  logic                   u_lt_s;
  logic                   last_s;
  logic                   exit_s;
  logic [2:0]             next_res_s;

  // First valid requester searching from ptr+1, wrapping modulo NREQ.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IW-1:0]   ptr);
    logic [NREQ-1:0] g;
    logic            found;
    int              idx;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && valid[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  // Grant selection and operand mux; grants only in IDLE and out of reset.
  always_comb begin
    gnt_s     = '0;
    gnt_idx_s = '0;
    a_sel_s   = '0;
    b_sel_s   = '0;
    if (state_r == IDLE && rst_n) begin
      gnt_s = rr_pick(req_valid, ptr_r);
    end else begin
      gnt_s = '0;
    end
    for (int k = 0; k < NREQ; k++) begin
      gnt_idx_s = gnt_s[k] ? IW'(k) : gnt_idx_s;
      a_sel_s   = gnt_s[k] ? req_a[k*WIDTH +: WIDTH] : a_sel_s;
      b_sel_s   = gnt_s[k] ? req_b[k*WIDTH +: WIDTH] : b_sel_s;
    end
  end

  assign req_ready = gnt_s;

  // Pick digit j of the latched operands, MSB digit first.
  always_comb begin
    a_dig_s = '0;
    b_dig_s = '0;
    for (int k = 0; k < NDIG; k++) begin
      a_dig_s = (j_r == JW'(k)) ? a_r[WIDTH-1-CMP_DIGIT_W*k -: CMP_DIGIT_W] : a_dig_s;
      b_dig_s = (j_r == JW'(k)) ? b_r[WIDTH-1-CMP_DIGIT_W*k -: CMP_DIGIT_W] : b_dig_s;
    end
  end

  cmp2_unit u_cmp2 (
    .a  (a_dig_s),
    .b  (b_dig_s),
    .eq (u_eq_s),
    .gt (u_gt_s),
    .lt (u_lt_s)
  );

  // Once a digit differs the decision is frozen; later digits cannot change it.
  always_comb begin
    last_s = (j_r == JW'(NDIG - 1));
    if (decided_r) begin
      next_res_s = res_r;
    end else if (u_gt_s) begin
      next_res_s = RES_GT;
    end else if (u_lt_s) begin
      next_res_s = RES_LT;
    end else begin
      next_res_s = RES_EQ;
    end
`ifdef CMP_EARLY_EXIT_EN
    exit_s = last_s || !u_eq_s;
`else
    exit_s = last_s;
`endif
  end

  // Scheduler FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= IW'(NREQ - 1);
      id_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      j_r         <= '0;
      decided_r   <= 1'b0;
      res_r       <= RES_NONE;
      rsp_valid_r <= 1'b0;
      rsp_res_r   <= RES_NONE;
    end else begin
      case (state_r)
        IDLE: begin
          if (|gnt_s) begin
            a_r       <= a_sel_s;
            b_r       <= b_sel_s;
            id_r      <= gnt_idx_s;
            ptr_r     <= gnt_idx_s;
            j_r       <= '0;
            decided_r <= 1'b0;
            res_r     <= RES_NONE;
            state_r   <= CMP;
          end
        end
        CMP: begin
          if (!decided_r && !u_eq_s) begin
            decided_r <= 1'b1;
            res_r     <= next_res_s;
          end
          if (exit_s) begin
            rsp_valid_r <= 1'b1;
            rsp_res_r   <= next_res_s;
            state_r     <= RESP;
          end else begin
            j_r <= j_r + JW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_res_r   <= RES_NONE;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          rsp_res_r   <= RES_NONE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = id_r;
  assign rsp_eq    = |(rsp_res_r & RES_EQ);
  assign rsp_gt    = |(rsp_res_r & RES_GT);
  assign rsp_lt    = |(rsp_res_r & RES_LT);

endmodule

// File: tb/tb_cmp_sched.sv
// Self-checking bench for cmp_sched: vector table plus multi-cycle sequences.
module tb_cmp_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [1:0]            rsp_id;
  logic                  rsp_eq, rsp_gt, rsp_lt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] res;
    int         lat_early;
    int         lat_full;
  } vec_t;

  vec_t vecs[8];

  cmp_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_eq    (rsp_eq),
    .rsp_gt    (rsp_gt),
    .rsp_lt    (rsp_lt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits up to 'bound' cycles (sampling at negedge+1) for rsp_valid; lat = cycle count, 0 if none.
  task automatic wait_rsp(input int bound, output int lat);
    lat = 0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    req_valid                 = '0;
    req_valid[v.id]           = 1'b1;
    req_a[v.id*WIDTH +: WIDTH] = v.a;
    req_b[v.id*WIDTH +: WIDTH] = v.b;
    rsp_ready                 = 1'b1;
    #1;
    chk("vec_grant", 32'(req_ready), 32'(1 << v.id));
    // handshake at the next posedge; count cycles until rsp_valid
    @(negedge clk);
    req_valid = '0;
    #1;
    lat = 0;
    if (rsp_valid) begin
      lat = 1;
    end else begin
      chk("vec_ready_cmp", 32'(req_ready), 32'h0);
      wait_rsp(20, lat);
      if (lat != 0) lat = lat + 1;
    end
    chk("vec_latency", 32'(lat), 32'(EARLY ? v.lat_early : v.lat_full));
    chk("vec_result", 32'({rsp_eq, rsp_gt, rsp_lt}), 32'(v.res));
    chk("vec_id", 32'(rsp_id), 32'(v.id));
    @(negedge clk);
    #1;
    chk("vec_rsp_clear", 32'({rsp_valid, rsp_eq, rsp_gt, rsp_lt}), 32'h0);
  endtask

  initial begin
    int lat;
    int grants[$];
    int last_gnt;
    int nrsp;

    vecs[0] = '{0, 8'hA5, 8'hA5, EQ, 5, 5};
    vecs[1] = '{2, 8'h80, 8'h7F, GT, 2, 5};
    vecs[2] = '{1, 8'h1B, 8'h1C, LT, 4, 5};
    vecs[3] = '{3, 8'h00, 8'hFF, LT, 2, 5};
    vecs[4] = '{0, 8'hFF, 8'hFF, EQ, 5, 5};
    vecs[5] = '{1, 8'h03, 8'h02, GT, 5, 5};
    vecs[6] = '{3, 8'h0C, 8'h08, GT, 4, 5};
    vecs[7] = '{2, 8'h40, 8'h00, GT, 2, 5};

    // Reset state, with every requester asserting valid
    req_valid = 4'hF;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_result", 32'({rsp_eq, rsp_gt, rsp_lt}), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    req_valid = '0;
    rst_n     = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Round robin with all four requesters held valid
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = 8'(i * 17);
      req_b[i*WIDTH +: WIDTH] = 8'(i * 17);
    end
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    last_gnt  = -1;
    nrsp      = 0;
    for (int c = 0; c < 60 && grants.size() < 5; c++) begin
      #1;
      if (rsp_valid) begin
        nrsp++;
        chk("rr_rsp_id", 32'(rsp_id), 32'(last_gnt));
        chk("rr_rsp_eq", 32'({rsp_eq, rsp_gt, rsp_lt}), 32'(EQ));
      end
      if (req_ready != '0) begin
        chk("rr_onehot", 32'($onehot(req_ready)), 32'h1);
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) last_gnt = k;
        grants.push_back(last_gnt);
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("rr_grant_count", 32'(grants.size()), 32'd5);
    chk("rr_rsp_count", 32'(nrsp), 32'd4);
    for (int k = 0; k < grants.size(); k++) chk("rr_order", 32'(grants[k]), 32'(k % NREQ));
    wait_rsp(20, lat);

    // Response back-pressure: rsp_ready low three cycles, handshake on the fourth
    do_reset();
    req_valid[2]                = 1'b1;
    req_a[2*WIDTH +: WIDTH]     = 8'h80;
    req_b[2*WIDTH +: WIDTH]     = 8'h7F;
    rsp_ready                   = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid                   = 4'b0001;
    req_a[0 +: WIDTH]           = 8'h11;
    req_b[0 +: WIDTH]           = 8'h22;
    #1;
    if (!rsp_valid) wait_rsp(20, lat);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) begin
        @(negedge clk);
        if (c == 4) rsp_ready = 1'b1;
        #1;
      end
      chk("bp_hold_rsp", 32'({rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt}), 32'({1'b1, 2'd2, GT}));
      chk("bp_ready_low", 32'(req_ready), 32'h0);
    end
    @(negedge clk);
    #1;
    chk("bp_after_valid", 32'(rsp_valid), 32'h0);
    chk("bp_idle_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    #1;
    wait_rsp(20, lat);
    chk("bp_next_found", 32'(lat != 0), 32'h1);
    chk("bp_next_rsp", 32'({rsp_id, rsp_eq, rsp_gt, rsp_lt}), 32'({2'd0, LT}));

    // Reset during CMP of requester 3
    do_reset();
    rsp_ready                   = 1'b1;
    req_valid                   = 4'b1000;
    req_a[3*WIDTH +: WIDTH]     = 8'hA5;
    req_b[3*WIDTH +: WIDTH]     = 8'hA5;
    #1;
    chk("rm_grant3", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n             = 1'b0;
    req_valid         = 4'b1001;
    req_a[0 +: WIDTH] = 8'h10;
    req_b[0 +: WIDTH] = 8'h10;
    #1;
    chk("rm_ready_in_rst", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rm_no_rsp", 32'(rsp_valid), 32'h0);
    chk("rm_grant0_first", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (rsp_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("rm_rsp_found", 32'(lat != 0), 32'h1);
    chk("rm_rsp_id0", 32'({rsp_id, rsp_eq, rsp_gt, rsp_lt}), 32'({2'd0, EQ}));
    req_valid = '0;
    wait_rsp(20, lat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
